mc_controller: RTL and testbench

- Multi-cycle control unit for the 32-bit MIPS-subset core.
- Sits directly upstream of the datapath: consumes opc, func and zero; drives every datapath control input each cycle.
- Moore FSM plus a small Mealy term for branch PC load; one instruction completes in 3–5 cycles.

---
 rtl/mc_ctrl_pkg.sv | 193 +++++++++++++++++++
 rtl/mc_controller_if.sv | 33 +++
 rtl/alu_op_decoder.sv | 22 ++
 rtl/mc_controller.sv | 72 +++++++
 tb/tb_mc_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings and decode helpers for the multi-cycle controller
package mc_ctrl_pkg;

   localparam int STATE_W    = 4;
   localparam int NUM_STATES = 14;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_BNE   = 6'b000101;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;
   localparam logic [5:0] FUNC_AND = 6'b100100;
   localparam logic [5:0] FUNC_OR  = 6'b100101;
   localparam logic [5:0] FUNC_SLT = 6'b101010;
   localparam logic [5:0] FUNC_JR  = 6'b001000;

   // ALUOperation encodings
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // PCSrc selects
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_JUMP   = 2'd1;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
   localparam logic [1:0] PCSRC_A      = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH = 4'd0,
      S_DEC   = 4'd1,
      S_MADR  = 4'd2,
      S_MRD   = 4'd3,
      S_MWB   = 4'd4,
      S_MWR   = 4'd5,
      S_REX   = 4'd6,
      S_RWB   = 4'd7,
      S_IEX   = 4'd8,
      S_IWB   = 4'd9,
      S_BR    = 4'd10,
      S_JMP   = 4'd11,
      S_JAL   = 4'd12,
      S_JR    = 4'd13
   } state_t;

   // Registered Moore control word; illegal and the branch PCLoad are added outside
   typedef struct packed {
      logic       pc_load;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       jal_sig1;
      logic       mem_to_reg;
      logic       jal_sig2;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   // Dispatch out of DEC; FETCH here means the instruction is unsupported
   function automatic state_t decode_next(logic [5:0] opc, logic [5:0] func);
      state_t n;
      n = S_FETCH;
      case (opc)
         OPC_LW, OPC_SW:     n = S_MADR;
         OPC_ADDI, OPC_SLTI: n = S_IEX;
         OPC_BEQ, OPC_BNE:   n = S_BR;
         OPC_J:              n = S_JMP;
         OPC_JAL:            n = S_JAL;
         OPC_RTYPE: begin
            case (func)
               FUNC_JR:                                       n = S_JR;
               FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLT: n = S_REX;
               default:                                       n = S_FETCH;
            endcase
         end
         default:            n = S_FETCH;
      endcase
      return n;
   endfunction

   function automatic state_t next_state(state_t s, logic [5:0] opc, logic [5:0] func);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH: n = S_DEC;
         S_DEC:   n = decode_next(opc, func);
         S_MADR:  n = (opc == OPC_LW) ? S_MRD : ((opc == OPC_SW) ? S_MWR : S_FETCH);
         S_MRD:   n = S_MWB;
         S_REX:   n = S_RWB;
         S_IEX:   n = S_IWB;
         default: n = S_FETCH;
      endcase
      return n;
   endfunction

   // Control word shown while sitting in state s
   function automatic ctrl_t state_ctrl(state_t s, logic [5:0] opc, logic [2:0] rex_op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_src    = PCSRC_ALU;
            c.pc_load   = 1'b1;
         end
         S_DEC: begin
            c.alu_src_b = SRCB_IMM_SH;
            c.alu_op    = ALU_ADD;
         end
         S_MADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MWB: c.reg_write = 1'b1;
         S_MWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_REX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = rex_op;
         end
         S_RWB: begin
            c.reg_dst    = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_IEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = (opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
         end
         S_IWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_BR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_SUB;
            c.pc_src    = PCSRC_ALUOUT;
         end
         S_JMP: begin
            c.pc_src  = PCSRC_JUMP;
            c.pc_load = 1'b1;
         end
         S_JAL: begin
            c.pc_src    = PCSRC_JUMP;
            c.pc_load   = 1'b1;
            c.jal_sig1  = 1'b1;
            c.jal_sig2  = 1'b1;
            c.reg_write = 1'b1;
         end
         S_JR: begin
            c.pc_src  = PCSRC_A;
            c.pc_load = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller to datapath control bundle
interface mc_controller_if;
   logic [5:0] opc;
   logic [5:0] func;
   logic       zero;
   logic       PCLoad;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       JalSig1;
   logic       MemToReg;
   logic       JalSig2;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOperation;
   logic [1:0] PCSrc;
   logic       illegal;

   modport master (
      input  opc, func, zero,
      output PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
             JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, illegal
   );

   modport slave (
      output opc, func, zero,
      input  PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
             JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, illegal
   );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - R-type func to ALUOperation map
module alu_op_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] func,
   output logic [2:0] alu_op
);

   // Unknown func falls back to ADD; DEC already flags it as illegal
   always_comb begin
      alu_op = ALU_ADD;
      case (func)
         FUNC_ADD: alu_op = ALU_ADD;
         FUNC_SUB: alu_op = ALU_SUB;
         FUNC_AND: alu_op = ALU_AND;
         FUNC_OR:  alu_op = ALU_OR;
         FUNC_SLT: alu_op = ALU_SLT;
         default:  alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS-subset control FSM
module mc_controller
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = mc_ctrl_pkg::STATE_W
)(
   input logic          clk,
   input logic          rst,
   mc_controller_if.master bus
);

   logic [STATE_W-1:0] state_q;
   state_t             state;
   state_t             state_nxt;
   ctrl_t              ctrl_q;
   ctrl_t              ctrl_o;
   logic [2:0]         rex_op;
   logic               state_ok;
   logic               live;
   logic               br_take;

   alu_op_decoder u_alu_op_decoder (
      .func   (bus.func),
      .alu_op (rex_op)
   );

   assign state     = state_t'(state_q);
   assign state_nxt = next_state(state, bus.opc, bus.func);
   assign state_ok  = (state_q < STATE_W'(NUM_STATES));
   assign live      = !rst && state_ok;

   // State plus the Moore control word of the state being entered, both registered together
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH, OPC_RTYPE, ALU_ADD);
      end else begin
         state_q <= state_nxt;
         ctrl_q  <= state_ctrl(state_nxt, bus.opc, rex_op);
      end
   end

   // Reset or a stray encoding silences everything in the same cycle
   always_comb begin
      ctrl_o  = '0;
      br_take = 1'b0;
      if (live) begin
         ctrl_o  = ctrl_q;
         br_take = (state == S_BR) &&
                   (((bus.opc == OPC_BEQ) &&  bus.zero) ||
                    ((bus.opc == OPC_BNE) && !bus.zero));
      end
   end

   assign bus.PCLoad       = ctrl_o.pc_load | br_take;
   assign bus.IorD         = ctrl_o.iord;
   assign bus.MemRead      = ctrl_o.mem_read;
   assign bus.MemWrite     = ctrl_o.mem_write;
   assign bus.IRWrite      = ctrl_o.ir_write;
   assign bus.RegDst       = ctrl_o.reg_dst;
   assign bus.JalSig1      = ctrl_o.jal_sig1;
   assign bus.MemToReg     = ctrl_o.mem_to_reg;
   assign bus.JalSig2      = ctrl_o.jal_sig2;
   assign bus.RegWrite     = ctrl_o.reg_write;
   assign bus.ALUSrcA      = ctrl_o.alu_src_a;
   assign bus.ALUSrcB      = ctrl_o.alu_src_b;
   assign bus.ALUOperation = ctrl_o.alu_op;
   assign bus.PCSrc        = ctrl_o.pc_src;
   assign bus.illegal      = live && (state == S_DEC) &&
                             (decode_next(bus.opc, bus.func) == S_FETCH);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed and randomized checks of mc_controller
module tb_mc_controller;

   typedef struct packed {
      logic       pcload, iord, memread, memwrite, irwrite, regdst, jal1, memtoreg, jal2, regwrite, srca;
      logic [1:0] srcb;
      logic [2:0] aluop;
      logic [1:0] pcsrc;
      logic       illegal;
   } obs_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   obs_t obs;

   mc_controller_if ifc ();

   mc_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   assign obs = {ifc.PCLoad, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.IRWrite, ifc.RegDst,
                 ifc.JalSig1, ifc.MemToReg, ifc.JalSig2, ifc.RegWrite, ifc.ALUSrcA,
                 ifc.ALUSrcB, ifc.ALUOperation, ifc.PCSrc, ifc.illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_legal(logic [5:0] opc, logic [5:0] func);
      bit [5:0] ops[9]   = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b000010, 6'b000011};
      bit [5:0] funcs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
      bit ok = 0;
      foreach (ops[i]) if (ops[i] == opc) ok = 1;
      if (ok && opc == 6'b000000) begin
         ok = 0;
         foreach (funcs[i]) if (funcs[i] == func) ok = 1;
      end
      return ok;
   endfunction

   // Cycles per instruction, counting FETCH
   function automatic int inst_len(logic [5:0] opc, logic [5:0] func);
      if (!is_legal(opc, func)) return 2;
      if (opc == 6'b100011) return 5;
      if (opc == 6'b101011 || opc == 6'b001000 || opc == 6'b001010) return 4;
      if (opc == 6'b000000 && func != 6'b001000) return 4;
      return 3;
   endfunction

   // Expected control word in cycle cyc (0 = FETCH) of an instruction
   function automatic obs_t model(logic [5:0] opc, logic [5:0] func, logic zero, int cyc);
      obs_t e = '0;
      bit is_mem = (opc == 6'b100011) || (opc == 6'b101011);
      bit is_r   = (opc == 6'b000000) && func != 6'b001000;
      bit is_imm = (opc == 6'b001000) || (opc == 6'b001010);
      if (cyc == 0) begin
         e.memread = 1; e.irwrite = 1; e.srcb = 2'd1; e.aluop = 3'b010; e.pcload = 1;
      end else if (cyc == 1) begin
         e.srcb = 2'd3; e.aluop = 3'b010; e.illegal = !is_legal(opc, func);
      end else if (is_mem) begin
         if (cyc == 2) begin e.srca = 1; e.srcb = 2'd2; e.aluop = 3'b010; end
         else if (opc == 6'b101011) begin e.iord = 1; e.memwrite = 1; end
         else if (cyc == 3) begin e.iord = 1; e.memread = 1; end
         else e.regwrite = 1;
      end else if (is_r) begin
         if (cyc == 2) begin
            e.srca = 1;
            case (func)
               6'b100010: e.aluop = 3'b110;
               6'b100100: e.aluop = 3'b000;
               6'b100101: e.aluop = 3'b001;
               6'b101010: e.aluop = 3'b111;
               default:   e.aluop = 3'b010;
            endcase
         end else begin
            e.regdst = 1; e.memtoreg = 1; e.regwrite = 1;
         end
      end else if (is_imm) begin
         if (cyc == 2) begin
            e.srca = 1; e.srcb = 2'd2; e.aluop = (opc == 6'b001010) ? 3'b111 : 3'b010;
         end else begin
            e.memtoreg = 1; e.regwrite = 1;
         end
      end else if (opc == 6'b000100 || opc == 6'b000101) begin
         e.srca = 1; e.aluop = 3'b110; e.pcsrc = 2'd2;
         e.pcload = (opc == 6'b000100) ? zero : !zero;
      end else if (opc == 6'b000010) begin
         e.pcsrc = 2'd1; e.pcload = 1;
      end else if (opc == 6'b000011) begin
         e.pcsrc = 2'd1; e.pcload = 1; e.jal1 = 1; e.jal2 = 1; e.regwrite = 1;
      end else begin
         e.pcsrc = 2'd3; e.pcload = 1;
      end
      return e;
   endfunction

   task automatic check(string tag, int cyc, obs_t exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   // Entered 2 time units into the FETCH cycle; leaves at the same point of the next FETCH
   task automatic run_instr(string tag, logic [5:0] opc, logic [5:0] func, int zmode);
      int n = inst_len(opc, func);
      ifc.opc  = opc;
      ifc.func = func;
      for (int c = 0; c < n; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #2;
         end
         ifc.zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
         #1;
         check(tag, c, model(opc, func, ifc.zero, c));
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [5:0] ops[9] = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b000010, 6'b000011};
      logic [5:0] funcs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
      logic [5:0] ro;
      logic [5:0] rf;
      total = 0;
      bad   = 0;
      rst      = 1'b1;
      ifc.opc  = 6'b100011;
      ifc.func = 6'b000000;
      ifc.zero = 1'b0;

      #1;
      check("reset_pre", 0, '0);
      @(posedge clk); #2;
      check("reset_1", 0, '0);
      @(posedge clk); #2;
      check("reset_2", 0, '0);
      rst = 1'b0;

      run_instr("lw", 6'b100011, 6'h00, -1);
      run_instr("sw", 6'b101011, 6'h15, -1);
      foreach (funcs[i]) run_instr("rtype", 6'b000000, funcs[i], -1);
      run_instr("addi", 6'b001000, 6'h00, -1);
      run_instr("slti", 6'b001010, 6'h00, -1);
      run_instr("beq_z1", 6'b000100, 6'h00, 1);
      run_instr("beq_z0", 6'b000100, 6'h00, 0);
      run_instr("bne_z1", 6'b000101, 6'h00, 1);
      run_instr("bne_z0", 6'b000101, 6'h00, 0);
      run_instr("j", 6'b000010, 6'h00, -1);
      run_instr("jal", 6'b000011, 6'h00, -1);
      run_instr("illegal_opc", 6'b111111, 6'h00, -1);
      run_instr("illegal_func", 6'b000000, 6'b111111, -1);

      // Abort an lw in its MRD cycle
      ifc.opc  = 6'b100011;
      ifc.func = 6'h00;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #2;
         end
         #1;
         check("abort_pre", c, model(6'b100011, 6'h00, 1'b0, c));
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_rst", 3, '0);
      @(posedge clk); #2;
      rst = 1'b0;
      run_instr("after_abort", 6'b101011, 6'h00, -1);

      for (int k = 0; k < 200; k++) begin
         int sel = $urandom_range(0, 10);
         if (sel < 9) ro = ops[sel];
         else if (sel == 9) ro = 6'($urandom);
         else ro = 6'b000000;
         if ($urandom_range(0, 6) == 0) rf = 6'($urandom);
         else rf = funcs[$urandom_range(0, 5)];
         run_instr("random", ro, rf, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
